// File: rtl/sram_mbist_pkg.sv
// sram_mbist shared types: FSM states, March C- element table, background helper.
package sram_mbist_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [2:0] E_W0     = 3'd0;
   localparam logic [2:0] E_UP_R0  = 3'd1;
   localparam logic [2:0] E_UP_R1  = 3'd2;
   localparam logic [2:0] E_DN_R0  = 3'd3;
   localparam logic [2:0] E_DN_R1  = 3'd4;
   localparam logic [2:0] E_R0     = 3'd5;
   localparam logic [2:0] E_LAST   = E_R0;

   // rd: first op at an address is a read; pair: read then write
   typedef struct packed {
      logic down;
      logic pair;
      logic rd;
      logic rd_val;
      logic wr_val;
   } elem_t;

   localparam elem_t ELEM_TBL [8] = '{
      elem_t'(5'b00000),
      elem_t'(5'b01101),
      elem_t'(5'b01110),
      elem_t'(5'b11101),
      elem_t'(5'b11110),
      elem_t'(5'b00100),
      elem_t'(5'b00000),
      elem_t'(5'b00000)
   };

   // Background bit: solid pass is all zeros, checkerboard
   // pass is 0xAAAA.. on odd addresses and 0x5555.. on even.
   function automatic logic bg_bit(
      input logic pass,
      input logic addr0,
      input logic bit_odd
   );
      return pass & (addr0 ~^ bit_odd);
   endfunction

endpackage

// File: rtl/sram_mbist_cmp.sv
// sram_mbist read-data checker: expectation delay line,
// comparator and first-fail capture.
module sram_mbist_cmp #(
   parameter int AW = 9,
   parameter int DW = 16,
   parameter int RL = 1
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_clr,
   input  logic          i_push,
   input  logic [DW-1:0] i_exp,
   input  logic [AW-1:0] i_addr,
   input  logic [3:0]    i_elem,
   input  logic [DW-1:0] i_q,
   output logic          o_fail,
   output logic [AW-1:0] o_fail_addr,
   output logic [3:0]    o_fail_elem
);

   localparam int PW = DW + AW + 4;

   logic [RL-1:0]         r_vld;
   logic [RL-1:0][PW-1:0] r_pipe;
   logic                  r_fail;
   logic [AW-1:0]         r_fail_addr;
   logic [3:0]            r_fail_elem;

   logic [PW-1:0] w_tail;
   logic [DW-1:0] w_t_exp;
   logic [AW-1:0] w_t_addr;
   logic [3:0]    w_t_elem;
   logic          w_mis;

   assign w_tail   = r_pipe[RL-1];
   assign w_t_exp  = w_tail[PW-1 -: DW];
   assign w_t_addr = w_tail[4 +: AW];
   assign w_t_elem = w_tail[3:0];
   assign w_mis    = r_vld[RL-1] & (i_q != w_t_exp);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_vld  <= '0;
         r_pipe <= '0;
      end else begin
         r_vld[0]  <= i_push;
         r_pipe[0] <= {i_exp, i_addr, i_elem};
         for (int i = 1; i < RL; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_elem <= '0;
      end else if (i_clr) begin
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_elem <= '0;
      end else if (w_mis) begin
         r_fail <= 1'b1;
         if (!r_fail) begin
            r_fail_addr <= w_t_addr;
            r_fail_elem <= w_t_elem;
         end
      end
   end

   assign o_fail      = r_fail;
   assign o_fail_addr = r_fail_addr;
   assign o_fail_elem = r_fail_elem;

endmodule

// File: rtl/sram_mbist.sv
// March C- BIST sequencer for one SRAM macro.
// Define SRAM_MBIST_CKBD_EN to add a checkerboard pass.
module sram_mbist
   import sram_mbist_pkg::*;
#(
   parameter int ADDR_BIT_COUNT = 9,
   parameter int WORDS          = 512,
   parameter int DATA_WIDTH     = 16,
   parameter int READ_LATENCY   = 1
) (
   input  logic                      CLK,
   input  logic                      RSTN,
   input  logic                      START,
   output logic                      BUSY,
   output logic                      DONE,
   output logic                      FAIL,
   output logic [ADDR_BIT_COUNT-1:0] FAIL_ADDR,
   output logic [3:0]                FAIL_ELEM,
   output logic                      CE,
   output logic                      WE,
   output logic [ADDR_BIT_COUNT-1:0] ADDR,
   output logic [DATA_WIDTH-1:0]     D,
   input  logic [DATA_WIDTH-1:0]     Q
);

   localparam int AW = ADDR_BIT_COUNT;
   localparam int DW = DATA_WIDTH;
   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [AW-1:0] LAST = AW'(WORDS - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   function automatic logic [DW-1:0] pat(
      input logic v,
      input logic p,
      input logic a0
   );
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) r[i] = v ^ bg_bit(p, a0, i[0]);
      return r;
   endfunction

   logic [1:0]    r_state;
   logic [2:0]    r_elem;
   logic          r_op;
   logic [CW-1:0] r_cnt;
   logic          r_ce;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_d;
   logic          r_busy;
   logic          r_done;

   logic          w_start;
   logic          w_pass;
   logic          w_step_done;
   logic          w_addr_end;
   logic          w_wrap;
   logic          w_last_op;
   logic          w_push;
   logic [DW-1:0] w_exp;
   logic [2:0]    w_n_elem;
   logic          w_n_op;
   logic [AW-1:0] w_n_addr;
   logic          w_n_pass;
   logic          w_n_we;
   logic [DW-1:0] w_n_d;

   assign w_start = START & ((r_state == S_IDLE) | (r_state == S_DONE));

   assign w_step_done = ~ELEM_TBL[r_elem].pair | r_op;
   assign w_addr_end  = ELEM_TBL[r_elem].down ? (r_addr == '0)
                                              : (r_addr == LAST);
   assign w_wrap = w_step_done & w_addr_end & (r_elem == E_LAST);

`ifdef SRAM_MBIST_CKBD_EN
   logic r_pass;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         r_pass <= 1'b0;
      else if (w_start)
         r_pass <= 1'b0;
      else if (r_state == S_RUN && w_wrap)
         r_pass <= 1'b1;
   end

   assign w_pass    = r_pass;
   assign w_last_op = w_wrap & r_pass;
`else
   assign w_pass    = 1'b0;
   assign w_last_op = w_wrap;
`endif

   assign w_n_pass = w_pass | w_wrap;

   always_comb begin
      w_n_elem = r_elem;
      w_n_op   = 1'b0;
      w_n_addr = r_addr;
      if (!w_step_done) begin
         w_n_op = 1'b1;
      end else if (!w_addr_end) begin
         w_n_addr = ELEM_TBL[r_elem].down ? r_addr - ONE
                                          : r_addr + ONE;
      end else if (r_elem == E_LAST) begin
         w_n_elem = E_W0;
         w_n_addr = '0;
      end else begin
         w_n_elem = r_elem + 3'd1;
         w_n_addr = ELEM_TBL[r_elem + 3'd1].down ? LAST : '0;
      end
   end

   assign w_n_we = ~(ELEM_TBL[w_n_elem].rd & ~w_n_op);
   assign w_n_d  = pat(ELEM_TBL[w_n_elem].wr_val, w_n_pass,
                       w_n_addr[0]);

   assign w_push = r_ce & ~r_we;
   assign w_exp  = pat(ELEM_TBL[r_elem].rd_val, w_pass, r_addr[0]);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= S_IDLE;
         r_elem  <= E_W0;
         r_op    <= 1'b0;
         r_cnt   <= '0;
         r_ce    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_d     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (START) begin
                  r_state <= S_RUN;
                  r_elem  <= E_W0;
                  r_op    <= 1'b0;
                  r_ce    <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= '0;
                  r_d     <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_last_op) begin
                  r_state <= S_DRAIN;
                  r_ce    <= 1'b0;
                  r_we    <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_elem <= w_n_elem;
                  r_op   <= w_n_op;
                  r_addr <= w_n_addr;
                  r_we   <= w_n_we;
                  r_d    <= w_n_d;
               end
            end
            S_DRAIN: begin
               // wait for the last read to reach the comparator
               if (r_cnt == CW'(READ_LATENCY - 1)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   sram_mbist_cmp #(
      .AW (AW),
      .DW (DW),
      .RL (READ_LATENCY)
   ) u_cmp (
      .i_clk       (CLK),
      .i_rstn      (RSTN),
      .i_clr       (w_start),
      .i_push      (w_push),
      .i_exp       (w_exp),
      .i_addr      (r_addr),
      .i_elem      ({w_pass, r_elem}),
      .i_q         (Q),
      .o_fail      (FAIL),
      .o_fail_addr (FAIL_ADDR),
      .o_fail_elem (FAIL_ELEM)
   );

   assign BUSY = r_busy;
   assign DONE = r_done;
   assign CE   = r_ce;
   assign WE   = r_we;
   assign ADDR = r_addr;
   assign D    = r_d;

endmodule
